// File: rtl/piezo_pkg.sv
// Shared types and constants for the piezo tone player.
// The optional inter-note gap is enabled with the PIEZO_GAP_EN macro.
package piezo_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      GAP
   } state_t;

   localparam int unsigned PER_W_DEF     = 16;
   localparam int unsigned DUR_W_DEF     = 24;
   localparam int unsigned FAST_SHIFT    = 4;
   localparam int unsigned GAP_CLKS      = 4096;
   localparam int unsigned GAP_CLKS_FAST = 256;
   localparam int unsigned GAP_W         = 13;

endpackage

// File: rtl/piezo_div.sv
// Half-period divider: the phase starts high on restart and toggles
// each time the counter wraps from period-1 back to 0.
module piezo_div
   import piezo_pkg::*;
#(
   parameter int unsigned PER_W = PER_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_restart,
   input  logic             i_en,
   input  logic [PER_W-1:0] i_period,
   output logic             o_phase
);

   logic [PER_W-1:0] r_cnt;
   logic             r_phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (i_restart) begin
         r_cnt   <= '0;
         r_phase <= 1'b1;
      end else if (i_en) begin
         if (r_cnt == i_period - PER_W'(1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_cnt <= r_cnt + PER_W'(1);
         end
      end
   end

   assign o_phase = r_phase;

endmodule

// File: rtl/piezo_tone.sv
// Note playback: drives a differential square wave for each handed-over note,
// then pulses note_done. Optional silent gap after each note: PIEZO_GAP_EN.
module piezo_tone
   import piezo_pkg::*;
#(
   parameter int unsigned PER_W    = PER_W_DEF,
   parameter int unsigned DUR_W    = DUR_W_DEF,
   parameter int unsigned FAST_SIM = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             note_vld,
   input  logic [PER_W-1:0] note_period,
   input  logic [DUR_W-1:0] note_dur,
   output logic             note_rdy,
   output logic             note_done,
   output logic             busy,
   output logic             piezo,
   output logic             piezo_n
);

   state_t           r_state, w_state_nxt;
   logic [DUR_W-1:0] r_dur, w_dur_nxt;
   logic [DUR_W-1:0] w_dur_shift, w_dur_eff;
   logic [PER_W-1:0] r_per, w_per_nxt;
   logic             r_done, w_done_nxt;
   logic             w_load, w_hs, w_last, w_tone, w_phase;

`ifdef PIEZO_GAP_EN
   localparam int unsigned GAP_LEN = (FAST_SIM != 0) ? GAP_CLKS_FAST : GAP_CLKS;
   logic [GAP_W-1:0] r_gap, w_gap_nxt;
`endif

   // Shift truncates; a zero-length result still plays one cycle.
   assign w_dur_shift = (FAST_SIM != 0) ? (note_dur >> FAST_SHIFT) : note_dur;
   assign w_dur_eff   = (w_dur_shift == '0) ? DUR_W'(1) : w_dur_shift;

   assign w_last = (r_state == PLAY) && (r_dur == DUR_W'(1));

`ifdef PIEZO_GAP_EN
   assign note_rdy = (r_state == IDLE);
`else
   assign note_rdy = (r_state == IDLE) || w_last;
`endif

   assign w_hs = note_vld & note_rdy;

   always_comb begin
      w_state_nxt = r_state;
      w_dur_nxt   = r_dur;
      w_per_nxt   = r_per;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;
`ifdef PIEZO_GAP_EN
      w_gap_nxt   = r_gap;
`endif
      case (r_state)
         IDLE: begin
            if (w_hs) w_load = 1'b1;
         end
         PLAY: begin
            if (w_last) begin
               w_done_nxt = 1'b1;
`ifdef PIEZO_GAP_EN
               w_state_nxt = GAP;
               w_gap_nxt   = GAP_W'(GAP_LEN);
`else
               if (w_hs) w_load = 1'b1;
               else      w_state_nxt = IDLE;
`endif
            end else begin
               w_dur_nxt = r_dur - DUR_W'(1);
            end
         end
`ifdef PIEZO_GAP_EN
         GAP: begin
            if (r_gap == GAP_W'(1)) w_state_nxt = IDLE;
            else                    w_gap_nxt   = r_gap - GAP_W'(1);
         end
`endif
         default: w_state_nxt = IDLE;
      endcase
      if (w_load) begin
         w_state_nxt = PLAY;
         w_dur_nxt   = w_dur_eff;
         w_per_nxt   = note_period;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_dur   <= '0;
         r_per   <= '0;
         r_done  <= 1'b0;
`ifdef PIEZO_GAP_EN
         r_gap   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_dur   <= w_dur_nxt;
         r_per   <= w_per_nxt;
         r_done  <= w_done_nxt;
`ifdef PIEZO_GAP_EN
         r_gap   <= w_gap_nxt;
`endif
      end
   end

   assign w_tone = (r_state == PLAY) && (r_per != '0);

   piezo_div #(
      .PER_W (PER_W)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .i_restart (w_load),
      .i_en      (w_tone),
      .i_period  (r_per),
      .o_phase   (w_phase)
   );

   assign piezo     = w_tone & w_phase;
   assign piezo_n   = w_tone & ~w_phase;
   assign busy      = (r_state != IDLE);
   assign note_done = r_done;

endmodule

// File: doc/piezo_tone.md
Name: piezo_tone

Overview:
- Note-playback stage directly downstream of the fanfare sequencer. The sequencer hands over one note at a time (half-period, duration) on a valid/ready handshake.
- This block drives the differential piezo pins with a square wave for exactly the note's duration, then pulses note_done so the sequencer can issue the next note.
- Rests (period 0) are silent notes.

Parameters:
- PER_W, 16, width of note_period (half-period in clk cycles)
- DUR_W, 24, width of note_dur (clk cycles)
- FAST_SIM, 0, 1 = duration right-shifted by 4 (divide by 16) for simulation

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous active-high reset
- note_vld  in  1  note request valid
- note_period  in  PER_W  half-period in clks; 0 = rest
- note_dur  in  DUR_W  note length in clks (before FAST_SIM scaling)
- note_rdy  out  1  block can accept a note this cycle
- note_done  out  1  one-cycle pulse after a note's last cycle
- busy  out  1  high while a note (or gap) is in progress
- piezo  out  1  piezo drive
- piezo_n  out  1  complementary piezo drive

Behaviour:
- Reset (synchronous, rst=1 at posedge): state IDLE; piezo=0, piezo_n=0, note_done=0, busy=0, all counters 0. note_rdy=1 from the first cycle after reset. Reset mid-note aborts immediately with no note_done.
- Handshake: transfer occurs on a posedge with note_vld & note_rdy (cycle T). Period and effective duration are latched at T.
  - Effective duration = note_dur >> 4 if FAST_SIM, else note_dur.
  - An effective duration of 0 is treated as 1.
- note_rdy = 1 in IDLE, and in the final PLAY cycle when PIEZO_GAP_EN is not defined. No input is sampled otherwise.
- State IDLE -> PLAY on handshake.
- PLAY occupies cycles T+1 .. T+D, where D is the effective duration.
  - Tone (period P>0): piezo=1 at T+1 and toggles every P cycles. piezo_n = ~piezo throughout PLAY.
  - Rest (P=0): piezo=0, piezo_n=0.
  - busy=1 throughout PLAY.
- Half-period counter: counts 0..P-1 and wraps to 0 with a toggle. Reloaded at every note start so phase restarts, including back-to-back notes.
- Duration counter: loads D, decrements each PLAY cycle; value 1 marks the last cycle. No underflow is possible.
- After the last PLAY cycle:
  - note_done=1 for exactly cycle T+D+1.
  - Next state is PLAY if a new note was accepted in the last cycle (the new note's first cycle is T+D+1), else GAP (feature on) or IDLE.
  - In IDLE, piezo=piezo_n=0.
- Simultaneous events: rst wins over everything. A handshake in the last PLAY cycle and note_done of the old note coexist normally.
- Width rules: counters are unsigned and sized PER_W/DUR_W. The FAST_SIM shift drops low bits (truncation).

Optional Feature:
- Macro PIEZO_GAP_EN.
- Defined: after each note, state GAP holds piezo=piezo_n=0 and busy=1 for GAP_CLKS cycles (package constant, 4096 clks; 256 if FAST_SIM). note_done is still issued at T+D+1. note_rdy=1 only in IDLE, reached after GAP ends.
- Undefined: no GAP state; back-to-back notes are allowed.

Decomposition:
- Package piezo_pkg: state enum {IDLE, PLAY, GAP}, FAST_SHIFT=4, GAP_CLKS / GAP_CLKS_FAST, default PER_W/DUR_W.
- Sub-module piezo_div: half-period divider with a restart input and toggle output.

Test Plan:
- Reset, then idle 10 cycles -> piezo=piezo_n=0, note_rdy=1, busy=0, no note_done.
- Note P=5, D=40 (FAST_SIM=0) -> piezo high T+1..T+5, low T+6..T+10, 8 half-periods total; piezo_n always inverted; note_done only at T+41.
- Rest P=0, D=20 -> piezo=piezo_n=0 for 20 cycles, busy=1, note_done at T+21.
- Back-to-back (no gap): note A P=3 D=12, then note B P=7 held valid -> B accepted at A's last cycle; B's first cycle T+13 has piezo=1 with reset phase; single note_done at T+13.
- FAST_SIM=1, note_dur=8388608, P=100 -> PLAY lasts 524288 cycles; note_dur=10 -> effective 0 -> 1 cycle.
- rst asserted mid-note (cycle T+7 of D=40) -> next cycle piezo=0, busy=0, note_rdy=1; no note_done.
